// File: rtl/opbus_arbiter_if.sv
// Shared operand-bus bundle: two requesting masters plus the single slave port.
// The arbiter connects through the slave modport. The environment connects through the master modport.
interface opbus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req;
  logic          m0_rw;
  logic          m0_lock;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_ack;
  logic          m0_err;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_rw;
  logic          m1_lock;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_ack;
  logic          m1_err;
  logic [DW-1:0] m1_rdata;

  logic          s_en;
  logic          s_rw;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] s_rdata;
  logic          s_ack;

  modport slave (
    input  m0_req, m0_rw, m0_lock, m0_addr, m0_wdata,
    input  m1_req, m1_rw, m1_lock, m1_addr, m1_wdata,
    input  s_rdata, s_ack,
    output m0_gnt, m0_ack, m0_err, m0_rdata,
    output m1_gnt, m1_ack, m1_err, m1_rdata,
    output s_en, s_rw, s_addr, s_wdata
  );

  modport master (
    output m0_req, m0_rw, m0_lock, m0_addr, m0_wdata,
    output m1_req, m1_rw, m1_lock, m1_addr, m1_wdata,
    output s_rdata, s_ack,
    input  m0_gnt, m0_ack, m0_err, m0_rdata,
    input  m1_gnt, m1_ack, m1_err, m1_rdata,
    input  s_en, s_rw, s_addr, s_wdata
  );
endinterface

// File: rtl/opbus_arbiter.sv
// Two-master round-robin operand-bus arbiter with optional lock for read-modify-write.
// A watchdog ends transfers that no slave acknowledges.
module opbus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  opbus_arbiter_if.slave   bus
);
  localparam int          CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, LOCKED} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;            // 0 = m0, 1 = m1
  logic          last_owner_q, last_owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          s_en_q, s_en_d;
  logic          s_rw_q, s_rw_d;
  logic [AW-1:0] s_addr_q, s_addr_d;
  logic [DW-1:0] s_wdata_q, s_wdata_d;

  logic own_req, own_lock, hit, expire;

  assign own_req  = owner_q ? bus.m1_req  : bus.m0_req;
  assign own_lock = owner_q ? bus.m1_lock : bus.m0_lock;
  assign hit      = s_en_q & bus.s_ack;
  // A slave ack on the final watchdog cycle takes precedence over expiry.
  assign expire   = s_en_q & ~bus.s_ack & (cnt_q == TMAX);

  always_comb begin
    // NOTE: every _d starts from a hold/default value so no path can infer a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    s_rw_d       = s_rw_q;
    s_addr_d     = s_addr_q;
    s_wdata_d    = s_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.m0_req | bus.m1_req) begin
          owner_d      = (bus.m0_req & bus.m1_req) ? ~last_owner_q : bus.m1_req;
          last_owner_d = owner_d;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if (hit)         state_d = own_lock ? LOCKED : IDLE;
        else if (expire) state_d = IDLE;
        else             cnt_d   = cnt_q + CW'(1);
      end
      LOCKED: begin
        if (own_req)        state_d = BUSY;
        else if (!own_lock) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == BUSY && state_q != BUSY) cnt_d = '0;

    s_en_d = (state_d == BUSY);
    gnt0_d = (state_d != IDLE) & ~owner_d;
    gnt1_d = (state_d != IDLE) &  owner_d;

    if (state_d == BUSY) begin
      s_rw_d    = owner_d ? bus.m1_rw    : bus.m0_rw;
      s_addr_d  = owner_d ? bus.m1_addr  : bus.m0_addr;
      s_wdata_d = owner_d ? bus.m1_wdata : bus.m0_wdata;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      cnt_q        <= '0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      s_en_q       <= 1'b0;
      s_rw_q       <= 1'b0;
      s_addr_q     <= '0;
      s_wdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      s_en_q       <= s_en_d;
      s_rw_q       <= s_rw_d;
      s_addr_q     <= s_addr_d;
      s_wdata_q    <= s_wdata_d;
    end
  end

  assign bus.s_en     = s_en_q;
  assign bus.s_rw     = s_rw_q;
  assign bus.s_addr   = s_addr_q;
  assign bus.s_wdata  = s_wdata_q;

  assign bus.m0_gnt   = gnt0_q;
  assign bus.m0_ack   = gnt0_q & (hit | expire);
  assign bus.m0_err   = gnt0_q & expire;
  assign bus.m0_rdata = (gnt0_q & ~expire) ? bus.s_rdata : '0;

  assign bus.m1_gnt   = gnt1_q;
  assign bus.m1_ack   = gnt1_q & (hit | expire);
  assign bus.m1_err   = gnt1_q & expire;
  assign bus.m1_rdata = (gnt1_q & ~expire) ? bus.s_rdata : '0;
endmodule

// File: tb/tb_opbus_arbiter.sv
// Directed bench for opbus_arbiter: a per-cycle vector table plus hand-written
// sequences for watchdog expiry, the ack/expiry race and reset mid-transfer.
module tb_opbus_arbiter;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  localparam logic [AW-1:0] A0   = 32'h0000_0100;
  localparam logic [AW-1:0] A1   = 32'h0000_0020;
  localparam logic [DW-1:0] W0   = 32'h1111_0000;
  localparam logic [DW-1:0] W1   = 32'h0000_0005;
  localparam logic [DW-1:0] S_RD = 32'hCAFE_0001;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  opbus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  opbus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per clock: inputs applied after the rising edge, outputs
  // compared on the falling edge. want = {gnt0,gnt1,s_en,ack0,ack1,err0,err1}.
  typedef struct {
    logic       rst;
    logic       r0, l0, w0;
    logic       r1, l1, w1;
    logic       ack;
    logic [6:0] want;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, r0, l0, w0, r1, l1, w1, ack,
                              input logic [6:0] want);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.l0 = l0; v.w0 = w0;
    v.r1 = r1; v.l1 = l1; v.w1 = w1; v.ack = ack; v.want = want;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, wanted %0h", name, $time, act, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [6:0] flags();
    return {bus.m0_gnt, bus.m1_gnt, bus.s_en, bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err};
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.m0_req = 0; bus.m0_rw = 0; bus.m0_lock = 0; bus.m0_addr = A0; bus.m0_wdata = W0;
    bus.m1_req = 0; bus.m1_rw = 0; bus.m1_lock = 0; bus.m1_addr = A1; bus.m1_wdata = W1;
    bus.s_rdata = S_RD;
    bus.s_ack   = 0;

    //                rst r0 l0 w0 r1 l1 w1 ack  g0 g1 en a0 a1 e0 e1
    // single read, s_ack two cycles after s_en, then stray s_ack while idle
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 7'b0000000));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 7'b1010000));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 7'b1010000));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 7'b1011000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7'b0000000));
    // reset, then both masters requesting continuously: 0,1,0,1
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 7'b0000000));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 7'b0000000));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 1, 7'b1011000));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 7'b0000000));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 1, 7'b0110100));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 7'b0000000));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 1, 7'b1011000));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 7'b0000000));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 1, 7'b0110100));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000));
    // m1 locked read then write; m0 requesting and locked out until release
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 7'b0000000));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 0, 1, 7'b0110100));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 1, 7'b0100000));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 1, 0, 7'b0100000));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 1, 1, 7'b0110100));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 7'b0000000));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 7'b1011000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000));
    // req dropped mid-transfer still completes with ack
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 7'b0000000));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 7'b1010000));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 7'b1011000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000));
    // lock held with no new req, then lock released -> idle
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 7'b0000000));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, 7'b1011000));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 7'b1000000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7'b1000000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000));

    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      cyc();
      reset = v.rst;
      bus.m0_req = v.r0; bus.m0_lock = v.l0; bus.m0_rw = v.w0;
      bus.m1_req = v.r1; bus.m1_lock = v.l1; bus.m1_rw = v.w1;
      bus.s_ack  = v.ack;
      smp();
      check($sformatf("row%0d flags", i), 64'(flags()), 64'(v.want));
      check($sformatf("row%0d m0_rdata", i), 64'(bus.m0_rdata), v.want[6] ? 64'(S_RD) : 64'h0);
      check($sformatf("row%0d m1_rdata", i), 64'(bus.m1_rdata), v.want[5] ? 64'(S_RD) : 64'h0);
      if (v.want[4]) begin
        check($sformatf("row%0d s_addr", i),  64'(bus.s_addr),  v.want[6] ? 64'(A0) : 64'(A1));
        check($sformatf("row%0d s_wdata", i), 64'(bus.s_wdata), v.want[6] ? 64'(W0) : 64'(W1));
        check($sformatf("row%0d s_rw", i),    64'(bus.s_rw),    v.want[6] ? 64'(v.w0) : 64'(v.w1));
      end
    end

    // Watchdog expiry with lock set: err on BUSY cycle TIMEOUT, lock broken.
    bus.m0_addr = 32'hFFFF_0000;
    bus.s_rdata = 32'hDEAD_BEEF;
    cyc(); bus.m0_req = 1; bus.m0_lock = 1; bus.m0_rw = 0; bus.s_ack = 0;
    smp(); check("to idle", 64'(flags()), 64'h0);
    for (int k = 1; k <= TIMEOUT; k++) begin
      cyc(); smp();
      check($sformatf("to cyc%0d gnt/en", k), 64'({bus.m0_gnt, bus.s_en}), 64'b11);
      check($sformatf("to cyc%0d ack", k), 64'(bus.m0_ack), (k == TIMEOUT) ? 64'h1 : 64'h0);
      check($sformatf("to cyc%0d err", k), 64'(bus.m0_err), (k == TIMEOUT) ? 64'h1 : 64'h0);
      if (k == TIMEOUT) begin
        check("to addr", 64'(bus.s_addr), 64'hFFFF_0000);
        check("to rdata", 64'(bus.m0_rdata), 64'h0);
      end
    end
    cyc(); bus.m0_req = 0; bus.m0_lock = 0;
    smp(); check("to after", 64'(flags()), 64'h0);

    // s_ack on the expiry cycle: normal completion with slave data.
    cyc(); bus.m0_req = 1;
    smp();
    for (int k = 1; k <= TIMEOUT; k++) begin
      cyc(); bus.s_ack = (k == TIMEOUT);
      smp();
      check($sformatf("race cyc%0d ack", k), 64'(bus.m0_ack), (k == TIMEOUT) ? 64'h1 : 64'h0);
      if (k == TIMEOUT) begin
        check("race err", 64'(bus.m0_err), 64'h0);
        check("race rdata", 64'(bus.m0_rdata), 64'hDEAD_BEEF);
      end
    end
    cyc(); bus.m0_req = 0; bus.s_ack = 0;
    smp(); check("race after", 64'(flags()), 64'h0);

    // Reset on BUSY cycle 3 of an m0 write; afterwards m0 wins the first tie.
    cyc(); bus.m0_req = 1; bus.m0_rw = 1;
    smp();
    for (int k = 1; k <= 3; k++) begin
      cyc();
      if (k == 3) reset = 1;
      smp(); check($sformatf("rst busy%0d", k), 64'(flags()), 64'b1010000);
    end
    cyc(); reset = 0; bus.m1_req = 1;
    smp();
    check("rst flags", 64'(flags()), 64'h0);
    check("rst s_bus", 64'({bus.s_rw, bus.s_addr, bus.s_wdata}), 64'h0);
    cyc(); smp();
    check("rst regrant", 64'({bus.m0_gnt, bus.m1_gnt}), 64'b10);
    cyc(); bus.m0_req = 0; bus.m1_req = 0; bus.m0_rw = 0;
    smp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
